univ_shift_register: RTL and testbench



---
 rtl/univ_shift_register.sv | 121 ++++++++++++
 tb/tb_univ_shift_register.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_register.sv
// Universal shift register: load/hold/clear, shift and rotate, and an autonomous burst engine.
// Optional parity ports are enabled by defining UNIV_SHIFT_PARITY_EN.
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_PARITY_EN
  ,
  input  logic             parity_in,
  output logic             parity_out,
  output logic             parity_err
`endif
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_len;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  // Requests longer than the register are clamped to a full-width burst
  assign w_len = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;
  assign w_shl = {r_q[WIDTH-2:0], serial_in_l};
  assign w_shr = {serial_in_r, r_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (burst_start) begin
            r_dir <= burst_dir;
            r_cnt <= w_len;
            if (w_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end
          end else begin
            case (mode)
              3'b001:  r_q <= parallel_in;
              3'b010:  r_q <= w_shl;
              3'b011:  r_q <= w_shr;
              3'b100:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
              3'b101:  r_q <= {r_q[0], r_q[WIDTH-1:1]};
              3'b110:  r_q <= '0;
              default: r_q <= r_q;
            endcase
          end
        end
        S_SHIFT: begin
          r_q   <= r_dir ? w_shr : w_shl;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign parallel_out   = r_q;
  assign serial_out_msb = r_q[WIDTH-1];
  assign serial_out_lsb = r_q[0];
  assign busy           = r_busy;
  assign done           = r_done;

`ifdef UNIV_SHIFT_PARITY_EN
  logic w_load;
  logic r_perr;

  assign w_load = (r_state == S_IDLE) && !burst_start && (mode == 3'b001);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= (^parallel_in) != parity_in;
    end
  end

  assign parity_out = ^r_q;
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: directed scenarios plus random stimulus
// against a behavioural model compared on every cycle.
module tb_univ_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] parallel_in = '0;
  logic             serial_in_l = 1'b0;
  logic             serial_in_r = 1'b0;
  logic             burst_start = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             burst_dir = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic             busy;
  logic             done;
`ifdef UNIV_SHIFT_PARITY_EN
  logic             parity_in = 1'b0;
  logic             parity_out;
  logic             parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  univ_shift_register #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .parallel_in    (parallel_in),
    .serial_in_l    (serial_in_l),
    .serial_in_r    (serial_in_r),
    .burst_start    (burst_start),
    .burst_len      (burst_len),
    .burst_dir      (burst_dir),
    .parallel_out   (parallel_out),
    .serial_out_msb (serial_out_msb),
    .serial_out_lsb (serial_out_lsb),
    .busy           (busy),
    .done           (done)
`ifdef UNIV_SHIFT_PARITY_EN
    ,
    .parity_in      (parity_in),
    .parity_out     (parity_out),
    .parity_err     (parity_err)
`endif
  );

  // Behavioural model: remaining burst bits as a plain integer
  logic [7:0] mq = '0;
  int         mrem = 0;
  logic       mdir = 1'b0;
  logic       mdone = 1'b0;
  bit         mvalid = 1'b0;
`ifdef UNIV_SHIFT_PARITY_EN
  logic       mperr = 1'b0;
`endif

  always @(posedge clk) begin
    logic nd;
    int   n;
    mvalid = 1'b1;
    nd = 1'b0;
    if (reset) begin
      mq = '0;
      mrem = 0;
`ifdef UNIV_SHIFT_PARITY_EN
      mperr = 1'b0;
`endif
    end else if (mrem > 0) begin
      if (mdir) mq = (mq >> 1) | (8'(serial_in_r) << 7);
      else      mq = (mq << 1) | 8'(serial_in_l);
      mrem = mrem - 1;
      if (mrem == 0) nd = 1'b1;
    end else if (burst_start) begin
      n = (int'(burst_len) > WIDTH) ? WIDTH : int'(burst_len);
      mdir = burst_dir;
      if (n == 0) nd = 1'b1;
      else mrem = n;
    end else begin
      case (mode)
        3'd1: begin
          mq = parallel_in;
`ifdef UNIV_SHIFT_PARITY_EN
          mperr = ($countones(parallel_in) % 2) != int'(parity_in);
`endif
        end
        3'd2: mq = (mq << 1) | 8'(serial_in_l);
        3'd3: mq = (mq >> 1) | (8'(serial_in_r) << 7);
        3'd4: mq = (mq << 1) | (mq >> 7);
        3'd5: mq = (mq >> 1) | (mq << 7);
        3'd6: mq = '0;
        default: ;
      endcase
    end
    mdone = nd;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      vectors++;
      if (parallel_out !== mq) begin
        miscompares++;
        $display("FAIL q: got %h want %h at %0t", parallel_out, mq, $time);
      end
      if (serial_out_msb !== mq[7] || serial_out_lsb !== mq[0]) begin
        miscompares++;
        $display("FAIL serial: got %b%b want %b%b at %0t",
                 serial_out_msb, serial_out_lsb, mq[7], mq[0], $time);
      end
      if (busy !== (mrem > 0)) begin
        miscompares++;
        $display("FAIL busy: got %b want %b at %0t", busy, mrem > 0, $time);
      end
      if (done !== mdone) begin
        miscompares++;
        $display("FAIL done: got %b want %b at %0t", done, mdone, $time);
      end
`ifdef UNIV_SHIFT_PARITY_EN
      if (parity_out !== ^mq || parity_err !== mperr) begin
        miscompares++;
        $display("FAIL parity: got %b%b want %b%b at %0t",
                 parity_out, parity_err, ^mq, mperr, $time);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Literal checks pin both the DUT and the model
  task automatic chk(string name, logic [31:0] act, logic [31:0] mdl,
                     logic [31:0] exp);
    if (act !== exp || mdl !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h model %h want %h", name, act, mdl, exp);
    end
  endtask

  task automatic load(logic [7:0] v);
    mode = 3'd1;
    parallel_in = v;
    tick();
    mode = 3'd0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_q", 32'(parallel_out), 32'(mq), 32'h0);
    chk("rst_bd", {busy, done}, {mrem > 0, mdone}, 32'h0);
    reset = 1'b0;

    load(8'hA5);
    chk("ld_a5", 32'(parallel_out), 32'(mq), 32'hA5);
    chk("ser_a5", {serial_out_msb, serial_out_lsb}, {mq[7], mq[0]}, 32'h3);
    mode = 3'd2; serial_in_l = 1'b1; tick();
    chk("shl", 32'(parallel_out), 32'(mq), 32'h4B);
    load(8'hA5);
    mode = 3'd3; serial_in_r = 1'b0; tick();
    chk("shr", 32'(parallel_out), 32'(mq), 32'h52);
    load(8'h81);
    mode = 3'd4; tick();
    chk("rol", 32'(parallel_out), 32'(mq), 32'h03);
    mode = 3'd5; tick();
    chk("ror", 32'(parallel_out), 32'(mq), 32'h81);
    mode = 3'd0;

    load(8'hF0);
    burst_start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0;
    serial_in_l = 1'b0; tick();
    burst_start = 1'b0;
    mode = 3'd1; parallel_in = 8'hFF;
    chk("b3_start", {busy, 8'(parallel_out)}, {mrem > 0, mq}, {1'b1, 8'hF0});
    tick();
    chk("b3_1", 32'(parallel_out), 32'(mq), 32'hE0);
    tick();
    chk("b3_2", 32'(parallel_out), 32'(mq), 32'hC0);
    tick();
    chk("b3_3", {busy, done, 8'(parallel_out)}, {mrem > 0, mdone, mq},
        {2'b01, 8'h80});
    mode = 3'd0;
    tick();
    chk("b3_done_off", 32'(done), 32'(mdone), 32'h0);

    load(8'h3C);
    burst_start = 1'b1; burst_len = 4'd6; burst_dir = 1'b1;
    serial_in_r = 1'b0; tick();
    burst_start = 1'b0;
    tick();
    tick();
    chk("abort_pre", 32'(parallel_out), 32'(mq), 32'h0F);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("abort", {busy, done, 8'(parallel_out)}, {mrem > 0, mdone, mq}, 32'h0);
    repeat (6) tick();

    load(8'h5A);
    burst_start = 1'b1; burst_len = 4'd0; tick();
    burst_start = 1'b0;
    chk("len0", {busy, done, 8'(parallel_out)}, {mrem > 0, mdone, mq},
        {2'b01, 8'h5A});
    tick();
    chk("len0_off", 32'(done), 32'(mdone), 32'h0);
    burst_start = 1'b1; burst_len = 4'd9; burst_dir = 1'b1;
    serial_in_r = 1'b1; tick();
    burst_start = 1'b0;
    repeat (7) tick();
    chk("len9_busy", 32'(busy), 32'(mrem > 0), 32'h1);
    tick();
    chk("len9_end", {busy, done, 8'(parallel_out)}, {mrem > 0, mdone, mq},
        {2'b01, 8'hFF});
    tick();

`ifdef UNIV_SHIFT_PARITY_EN
    parity_in = 1'b0;
    load(8'h07);
    chk("par_err1", {parity_err, parity_out}, {mperr, ^mq}, 32'h3);
    load(8'h03);
    chk("par_err0", {parity_err, parity_out}, {mperr, ^mq}, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      mode = 3'($urandom_range(0, 7));
      parallel_in = 8'($urandom);
      serial_in_l = 1'($urandom);
      serial_in_r = 1'($urandom);
      burst_start = ($urandom_range(0, 7) == 0);
      burst_len = 4'($urandom_range(0, 15));
      burst_dir = 1'($urandom);
`ifdef UNIV_SHIFT_PARITY_EN
      parity_in = 1'($urandom);
`endif
      tick();
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
